sa_buf_rr_arb: RTL and testbench

// - Shares one registered buffer stage between NUM_REQ valid/ready requesters.
// - Round-robin arbitration with optional burst hold; winner's payload goes into
//   a 2-entry output FIFO that drives a single downstream valid/ready port.
// - Sits in front of shared SA buffer/blackbox paths; the shared path never sees

---
 rtl/sa_buf_rr_arb.sv | 175 +++++++++++++++++
 tb/tb_sa_buf_rr_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_buf_rr_arb.sv
// sa_buf_rr_arb: round-robin arbiter with optional burst hold. It merges
// NUM_REQ valid/ready requesters into one 2-entry registered output FIFO.
// Ports:
//   sa_core_clk  - clock, rising edge
//   sa_core_rst  - asynchronous active-high reset
//   req_valid    - per-requester valid
//   req_pd       - packed payloads, requester i at [i*DW +: DW]
//   req_ready    - per-requester accept (one-hot or zero)
//   out_valid    - FIFO head valid
//   out_pd       - FIFO head payload
//   out_ready    - downstream accept
//   out_src      - requester index of the FIFO head
//   busy         - FIFO non-empty or burst lock held
module sa_buf_rr_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4,
    localparam int unsigned SW       = $clog2(NUM_REQ)
) (
    input  logic                  sa_core_clk,
    input  logic                  sa_core_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_pd,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_pd,
    input  logic                  out_ready,
    output logic [SW-1:0]         out_src,
    output logic                  busy
);

    localparam int unsigned BCW = 8;

    typedef enum logic {ST_ARB, ST_HOLD} state_t;

    state_t           state;
    logic [SW-1:0]    rr_ptr;
    logic [SW-1:0]    owner;
    logic [BCW-1:0]   burst_cnt;

    logic [1:0]       count;
    logic [DW-1:0]    head_pd;
    logic [SW-1:0]    head_src;
    logic [DW-1:0]    tail_pd;
    logic [SW-1:0]    tail_src;

    logic             space;
    logic             grant_vld;
    logic [SW-1:0]    grant_idx;
    int unsigned      cand;
    logic             push;
    logic             pop;
    logic [DW-1:0]    push_pd;

    // Index of the requester after idx, wrapping to 0.
    function automatic logic [SW-1:0] nxt_idx(input logic [SW-1:0] idx);
        return (idx == SW'(NUM_REQ - 1)) ? '0 : idx + SW'(1);
    endfunction

    // Space depends only on the registered count, so downstream ready never
    // reaches the requesters combinationally.
    assign space = (count < 2'd2);

    // Grant: owner while holding, else first valid at or above rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (state == ST_HOLD) begin
            grant_vld = req_valid[owner];
            grant_idx = owner;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = (32'(rr_ptr) + k) % NUM_REQ;
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(cand);
                end
            end
        end
    end

    // Ready is forced low while reset is held.
    always_comb begin
        req_ready = '0;
        if (grant_vld && space && !sa_core_rst) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    assign push    = |(req_ready & req_valid);
    assign pop     = out_valid && out_ready;
    assign push_pd = req_pd[32'(grant_idx)*DW +: DW];

    assign out_valid = (count != 2'd0);
    assign out_pd    = head_pd;
    assign out_src   = head_src;
    assign busy      = (count != 2'd0) || (state == ST_HOLD);

    // Arbitration FSM: burst lock and round-robin pointer.
    always_ff @(posedge sa_core_clk or posedge sa_core_rst) begin
        if (sa_core_rst) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (push) begin
                        if (BURST_MAX > 1) begin
                            state     <= ST_HOLD;
                            owner     <= grant_idx;
                            burst_cnt <= BCW'(1);
                        end else begin
                            rr_ptr <= nxt_idx(grant_idx);
                        end
                    end
                end
                ST_HOLD: begin
                    // Owner dropping valid releases the lock even when full.
                    if (!req_valid[owner]) begin
                        state  <= ST_ARB;
                        rr_ptr <= nxt_idx(owner);
                    end else if (push) begin
                        if (burst_cnt + BCW'(1) == BCW'(BURST_MAX)) begin
                            state     <= ST_ARB;
                            rr_ptr    <= nxt_idx(owner);
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                        end
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // Two-entry FIFO kept as head/tail registers so the head drives outputs directly.
    always_ff @(posedge sa_core_clk or posedge sa_core_rst) begin
        if (sa_core_rst) begin
            count    <= 2'd0;
            head_pd  <= '0;
            head_src <= '0;
            tail_pd  <= '0;
            tail_src <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pd  <= push_pd;
                        head_src <= grant_idx;
                    end else begin
                        tail_pd  <= push_pd;
                        tail_src <= grant_idx;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pd  <= tail_pd;
                    head_src <= tail_src;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    // Push requires space, so count is 1 here: new entry becomes head.
                    head_pd  <= push_pd;
                    head_src <= grant_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_buf_rr_arb.sv
// Directed testbench for sa_buf_rr_arb: one instance in pure round-robin mode
// (BURST_MAX=1) and one with burst hold (BURST_MAX=4), sharing clock and reset.
module tb_sa_buf_rr_arb;

    logic         clk;
    logic         rst;

    logic [3:0]   a_valid, b_valid;
    logic [127:0] a_pd, b_pd;
    logic [3:0]   a_rdy, b_rdy;
    logic         a_ov, b_ov;
    logic [31:0]  a_opd, b_opd;
    logic         a_ordy, b_ordy;
    logic [1:0]   a_src, b_src;
    logic         a_busy, b_busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [1:0] burst_seq [9];

    sa_buf_rr_arb #(.NUM_REQ(4), .DW(32), .BURST_MAX(1)) u_rr (
        .sa_core_clk (clk),
        .sa_core_rst (rst),
        .req_valid   (a_valid),
        .req_pd      (a_pd),
        .req_ready   (a_rdy),
        .out_valid   (a_ov),
        .out_pd      (a_opd),
        .out_ready   (a_ordy),
        .out_src     (a_src),
        .busy        (a_busy)
    );

    sa_buf_rr_arb #(.NUM_REQ(4), .DW(32), .BURST_MAX(4)) u_bu (
        .sa_core_clk (clk),
        .sa_core_rst (rst),
        .req_valid   (b_valid),
        .req_pd      (b_pd),
        .req_ready   (b_rdy),
        .out_valid   (b_ov),
        .out_pd      (b_opd),
        .out_ready   (b_ordy),
        .out_src     (b_src),
        .busy        (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk_pd(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        burst_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

        // Reset with arbitrary valids: nothing may be accepted.
        rst     = 1'b1;
        a_valid = 4'($urandom) | 4'b0001;
        b_valid = 4'($urandom) | 4'b0010;
        a_pd    = mk_pd(32'h100);
        b_pd    = mk_pd(32'h300);
        a_ordy  = 1'b0;
        b_ordy  = 1'b0;
        #3;
        chk("rst_a_rdy", 64'(a_rdy), 64'h0);
        chk("rst_b_rdy", 64'(b_rdy), 64'h0);
        chk("rst_a_ov", 64'(a_ov), 64'h0);
        chk("rst_a_busy", 64'(a_busy), 64'h0);
        chk("rst_a_src", 64'(a_src), 64'h0);
        chk("rst_a_pd", 64'(a_opd), 64'h0);
        step();
        step();
        chk("rst_held_b_rdy", 64'(b_rdy), 64'h0);
        rst     = 1'b0;
        a_valid = 4'b0;
        b_valid = 4'b0;
        step();
        chk("idle_a_rdy", 64'(a_rdy), 64'h0);
        chk("idle_a_ov", 64'(a_ov), 64'h0);
        chk("idle_b_ov", 64'(b_ov), 64'h0);

        // Pure round-robin: one accept per cycle, sources 0,1,2,3,0,1.
        a_ordy  = 1'b1;
        a_valid = 4'hF;
        #1;
        chk("rr_first_rdy", 64'(a_rdy), 64'h1);
        chk("rr_first_ov", 64'(a_ov), 64'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_ov", 64'(a_ov), 64'h1);
            chk("rr_src", 64'(a_src), 64'(k % 4));
            chk("rr_pd", 64'(a_opd), 64'(32'h100 + 32'(k % 4)));
            chk("rr_rdy", 64'(a_rdy), 64'(4'b0001 << ((k + 1) % 4)));
        end
        a_valid = 4'b0;
        step();
        chk("rr_drain_ov", 64'(a_ov), 64'h0);
        chk("rr_drain_busy", 64'(a_busy), 64'h0);

        // Burst of 4: requesters 1 and 2 alternate in groups of four.
        b_ordy  = 1'b1;
        b_valid = 4'b0110;
        #1;
        chk("burst_first_rdy", 64'(b_rdy), 64'h2);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("burst_src", 64'(b_src), 64'(burst_seq[k]));
            chk("burst_pd", 64'(b_opd), 64'(32'h300 + 32'(burst_seq[k])));
            chk("burst_busy", 64'(b_busy), 64'h1);
        end
        b_valid = 4'b0;
        step();
        chk("burst_drain_ov", 64'(b_ov), 64'h0);
        chk("burst_drain_busy", 64'(b_busy), 64'h0);

        // Early release: owner 3 drops valid after two accepts, 0 is next.
        b_valid = 4'b1000;
        #1;
        chk("rel_rdy3", 64'(b_rdy), 64'h8);
        step();
        chk("rel_src_a", 64'(b_src), 64'h3);
        step();
        chk("rel_src_b", 64'(b_src), 64'h3);
        b_valid = 4'b0001;
        #1;
        chk("rel_hold_rdy", 64'(b_rdy), 64'h0);
        step();
        chk("rel_grant0", 64'(b_rdy), 64'h1);
        step();
        chk("rel_src0", 64'(b_src), 64'h0);
        chk("rel_pd0", 64'(b_opd), 64'h300);
        b_valid = 4'b0;
        step();
        step();

        // Backpressure: exactly two accepts, then drain in accept order.
        a_pd    = mk_pd(32'h200);
        a_ordy  = 1'b0;
        a_valid = 4'hF;
        #1;
        chk("bp_rdy2", 64'(a_rdy), 64'h4);
        step();
        chk("bp_src_1st", 64'(a_src), 64'h2);
        chk("bp_rdy3", 64'(a_rdy), 64'h8);
        step();
        chk("bp_full_rdy", 64'(a_rdy), 64'h0);
        chk("bp_full_src", 64'(a_src), 64'h2);
        step();
        chk("bp_stall_rdy", 64'(a_rdy), 64'h0);
        chk("bp_stall_ov", 64'(a_ov), 64'h1);
        chk("bp_stall_pd", 64'(a_opd), 64'h202);
        a_valid = 4'b0011;
        a_ordy  = 1'b1;
        step();
        chk("bp_pop1_src", 64'(a_src), 64'h3);
        chk("bp_pop1_pd", 64'(a_opd), 64'h203);
        chk("bp_pop1_rdy", 64'(a_rdy), 64'h1);
        step();
        chk("bp_pop2_src", 64'(a_src), 64'h0);
        chk("bp_pop2_pd", 64'(a_opd), 64'h200);
        a_valid = 4'b0010;
        step();
        chk("bp_pop3_src", 64'(a_src), 64'h1);
        chk("bp_pop3_pd", 64'(a_opd), 64'h201);
        a_valid = 4'b0;
        step();
        chk("bp_empty_ov", 64'(a_ov), 64'h0);

        // Mid-operation reset with a full FIFO and the lock held.
        b_ordy  = 1'b0;
        b_valid = 4'b0100;
        step();
        step();
        chk("mid_busy", 64'(b_busy), 64'h1);
        chk("mid_full_rdy", 64'(b_rdy), 64'h0);
        chk("mid_ov", 64'(b_ov), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        b_valid = 4'b0101;
        #1;
        chk("mid_rst_ov", 64'(b_ov), 64'h0);
        chk("mid_rst_busy", 64'(b_busy), 64'h0);
        chk("mid_rst_rdy", 64'(b_rdy), 64'h1);
        b_ordy = 1'b1;
        step();
        chk("mid_after_src", 64'(b_src), 64'h0);
        chk("mid_after_pd", 64'(b_opd), 64'h300);
        chk("mid_after_ov", 64'(b_ov), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
